// File: rtl/fir_coeff_bank.sv
// ============================================================================
// fir_coeff_bank
//
// Double-buffered FIR coefficient register file. The microprocessor fills a
// shadow bank over a 32-bit byte-lane bus (two coefficients per word) and then
// requests a commit. The active bank driving the filter is replaced as a whole
// on the first swapOk strobe after the commit, so taps never change
// mid-sample.
//
// Parameters
//   NTAPS  number of coefficients, even, 2..64
//   CW     coefficient width, 2..16, signed two's complement
//
// Ports
//   busClk    in   bus and filter clock, rising edge
//   nReset    in   asynchronous active-low reset
//   addr      in   [12:0] byte address, word index = addr[WIW+1:2]
//   dataIn    in   [31:0] write data
//   dataOut   out  [31:0] combinational read data, 0 when cs = 0
//   cs        in   block select
//   wr0..wr3  in   byte-lane write enables
//   swapOk    in   filter safe-point strobe
//   coeffs    out  [NTAPS*CW-1:0] active bank, coefficient k at [k*CW +: CW]
//   swapDone  out  one-cycle pulse after the active bank updates
//   pending   out  commit requested, not yet applied
//
// Word map
//   0 .. NTAPS/2-1   coefficient pairs {2i+1 in [16+CW-1:16], 2i in [CW-1:0]}
//   NTAPS/2 (CTRL)   W: bit0 commit, bit9 clear wrErr
//                    R: bit8 pending, bit9 wrErr, [23:16] swapCnt
//   above CTRL       writes ignored, reads 0
//
// Build option
//   FIR_COEFF_ACTIVE_READ_EN  adds CTRL bit4 "banksel" (lane 0, read-write).
//                             When set, coefficient reads return the active
//                             bank instead of the shadow bank.
//
// FSM states
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no commit outstanding, shadow bank writable
//   PEND   | commit requested, waiting for swapOk; coefficient writes
//          | are discarded and flag wrErr
// ============================================================================
module fir_coeff_bank #(
    parameter int NTAPS = 8,
    parameter int CW    = 16
) (
    input  logic                  busClk,
    input  logic                  nReset,
    input  logic [12:0]           addr,
    input  logic [31:0]           dataIn,
    output logic [31:0]           dataOut,
    input  logic                  cs,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic                  wr2,
    input  logic                  wr3,
    input  logic                  swapOk,
    output logic [NTAPS*CW-1:0]   coeffs,
    output logic                  swapDone,
    output logic                  pending
);

    localparam int NW  = NTAPS / 2;
    localparam int WIW = $clog2(NW + 1);
    localparam logic [WIW-1:0] CTRL_IDX = WIW'(NW);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] shadow_q [NTAPS];
    logic [CW-1:0] shadow_d [NTAPS];
    logic [CW-1:0] active_q [NTAPS];
    logic [CW-1:0] active_d [NTAPS];

    logic          wr_err_q, wr_err_d;
    logic [7:0]    swap_cnt_q, swap_cnt_d;
    logic          swap_done_q;
    logic          banksel_bit;

    logic [WIW-1:0] idx;
    logic           bus_wr;
    logic           coeff_sel;
    logic           ctrl_sel;
    logic           coeff_wr;
    logic           coeff_wr_ok;
    logic           commit_req;
    logic           err_set;
    logic           err_clr;
    logic           swap_fire;

    logic           unused_addr_bits;

    // Merge one 16-bit lane pair into a CW-bit coefficient. Each enabled lane
    // replaces only the bits it covers; bits above CW are dropped.
    function automatic logic [CW-1:0] lane_merge(
        input logic [CW-1:0] old_val,
        input logic [15:0]   wdata,
        input logic          lane_hi,
        input logic          lane_lo
    );
        logic [15:0] mask;
        mask = {{8{lane_hi}}, {8{lane_lo}}};
        return (old_val & ~mask[CW-1:0]) | (wdata[CW-1:0] & mask[CW-1:0]);
    endfunction

    function automatic logic [15:0] sext16(input logic [CW-1:0] c);
        logic [15:0] r;
        r         = {16{c[CW-1]}};
        r[CW-1:0] = c;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign idx              = addr[WIW+1:2];
    assign unused_addr_bits = ^{addr[12:WIW+2], addr[1:0]};

    assign bus_wr      = cs & (wr0 | wr1 | wr2 | wr3);
    assign coeff_sel   = (idx < CTRL_IDX);
    assign ctrl_sel    = (idx == CTRL_IDX);
    assign coeff_wr    = bus_wr & coeff_sel;
    assign coeff_wr_ok = coeff_wr & ~pending;
    assign err_set     = coeff_wr & pending;
    assign commit_req  = cs & ctrl_sel & wr0 & dataIn[0];
    assign err_clr     = cs & ctrl_sel & wr1 & dataIn[9];

    // ------------------------------------------------------------------------
    // Commit FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge busClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Commit FSM: next state
    // A commit written on the swap edge re-arms PEND for the next commit.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (commit_req) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (swapOk && !commit_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Commit FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        pending   = 1'b0;
        swap_fire = 1'b0;
        if (state_q == S_PEND) begin
            pending   = 1'b1;
            swap_fire = swapOk;
        end
    end

    // ------------------------------------------------------------------------
    // Bank and status next-state
    // ------------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        if (coeff_wr_ok) begin
            for (int i = 0; i < NW; i++) begin
                if (idx == WIW'(i)) begin
                    shadow_d[2*i]   = lane_merge(shadow_q[2*i],   dataIn[15:0],  wr1, wr0);
                    shadow_d[2*i+1] = lane_merge(shadow_q[2*i+1], dataIn[31:16], wr3, wr2);
                end
            end
        end
    end

    always_comb begin
        active_d = active_q;
        if (swap_fire) begin
            active_d = shadow_q;
        end
    end

    // A new error on the same edge as a clear keeps the flag set.
    always_comb begin
        wr_err_d = wr_err_q;
        if (err_set) begin
            wr_err_d = 1'b1;
        end else if (err_clr) begin
            wr_err_d = 1'b0;
        end
    end

    assign swap_cnt_d = swap_fire ? (swap_cnt_q + 8'd1) : swap_cnt_q;

    always_ff @(posedge busClk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            wr_err_q    <= 1'b0;
            swap_cnt_q  <= 8'd0;
            swap_done_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            wr_err_q    <= wr_err_d;
            swap_cnt_q  <= swap_cnt_d;
            swap_done_q <= swap_fire;
        end
    end

    assign swapDone = swap_done_q;

`ifdef FIR_COEFF_ACTIVE_READ_EN
    logic banksel_q, banksel_d;

    always_comb begin
        banksel_d = banksel_q;
        if (cs && ctrl_sel && wr0) begin
            banksel_d = dataIn[4];
        end
    end

    always_ff @(posedge busClk or negedge nReset) begin
        if (!nReset) begin
            banksel_q <= 1'b0;
        end else begin
            banksel_q <= banksel_d;
        end
    end

    assign banksel_bit = banksel_q;
`else
    assign banksel_bit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Active bank output
    // ------------------------------------------------------------------------
    always_comb begin
        coeffs = '0;
        for (int k = 0; k < NTAPS; k++) begin
            coeffs[k*CW +: CW] = active_q[k];
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        dataOut = 32'h0000_0000;
        if (cs) begin
            if (ctrl_sel) begin
                dataOut = {8'h00, swap_cnt_q, 6'b000000, wr_err_q, pending,
                           3'b000, banksel_bit, 4'b0000};
            end else begin
                for (int i = 0; i < NW; i++) begin
                    if (idx == WIW'(i)) begin
                        if (banksel_bit) begin
                            dataOut = {sext16(active_q[2*i+1]), sext16(active_q[2*i])};
                        end else begin
                            dataOut = {sext16(shadow_q[2*i+1]), sext16(shadow_q[2*i])};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_bank.sv
module tb_fir_coeff_bank;

    logic         busClk;
    logic         nReset;
    logic [12:0]  addr;
    logic [31:0]  dataIn;
    logic         cs, cs12;
    logic         wr0, wr1, wr2, wr3;
    logic         swapOk;

    logic [31:0]  dataOut, dataOut12;
    logic [127:0] coeffs;
    logic [95:0]  coeffs12;
    logic         swapDone, swapDone12;
    logic         pending, pending12;

    int errors = 0;
    int checks = 0;

    localparam int CTRL = 4;

`ifdef FIR_COEFF_ACTIVE_READ_EN
    localparam logic [31:0] BANKSEL_RB = 32'h0000_0010;
`else
    localparam logic [31:0] BANKSEL_RB = 32'h0000_0000;
`endif

    fir_coeff_bank #(.NTAPS(8), .CW(16)) dut (
        .busClk(busClk), .nReset(nReset), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .cs(cs), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
        .swapOk(swapOk), .coeffs(coeffs), .swapDone(swapDone), .pending(pending)
    );

    fir_coeff_bank #(.NTAPS(8), .CW(12)) dut12 (
        .busClk(busClk), .nReset(nReset), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut12), .cs(cs12), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
        .swapOk(swapOk), .coeffs(coeffs12), .swapDone(swapDone12), .pending(pending12)
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge busClk);
        #1;
    endtask

    task automatic bus_write(input bit to12, input int idx, input logic [31:0] d,
                             input logic [3:0] lanes);
        addr   = 13'(idx * 4);
        dataIn = d;
        {wr3, wr2, wr1, wr0} = lanes;
        if (to12) cs12 = 1'b1;
        else      cs   = 1'b1;
        tick();
        cs = 1'b0; cs12 = 1'b0;
        {wr3, wr2, wr1, wr0} = 4'b0000;
        dataIn = 32'h0;
    endtask

    task automatic bus_read(input int idx, output logic [31:0] d, output logic [31:0] d12);
        addr = 13'(idx * 4);
        {wr3, wr2, wr1, wr0} = 4'b0000;
        cs = 1'b1; cs12 = 1'b1;
        #1;
        d   = dataOut;
        d12 = dataOut12;
        cs = 1'b0; cs12 = 1'b0;
    endtask

    logic [31:0] rd, rd12;

    initial begin
        nReset = 1'b0; addr = '0; dataIn = '0; cs = 1'b0; cs12 = 1'b0;
        {wr3, wr2, wr1, wr0} = 4'b0000; swapOk = 1'b0;

        // Reset
        repeat (2) @(posedge busClk);
        #1;
        check("rst_coeffs",  coeffs, 128'h0);
        check("rst_pending", {127'h0, pending}, 128'h0);
        check("rst_swapdone", {127'h0, swapDone}, 128'h0);
        @(negedge busClk);
        nReset = 1'b1;
        tick();
        bus_read(CTRL, rd, rd12);
        check("rst_ctrl", rd, 32'h0);

        // Lane writes
        bus_write(0, 1, 32'hFF3A_0123, 4'b1111);
        bus_read(1, rd, rd12);
        check("w1_readback", rd, 32'hFF3A_0123);
        check("w1_coeffs_unchanged", coeffs, 128'h0);
        bus_write(0, 0, 32'hAABB_CCDD, 4'b0001);
        bus_read(0, rd, rd12);
        check("lane0_only", rd, 32'h0000_00DD);
        bus_write(0, 0, 32'h1122_3344, 4'b1000);
        bus_read(0, rd, rd12);
        check("lane3_only", rd, 32'h1100_00DD);

        // Indices above CTRL and cs = 0
        bus_write(0, 5, 32'hFFFF_FFFF, 4'b1111);
        bus_read(5, rd, rd12);
        check("above_ctrl_rd5", rd, 32'h0);
        bus_read(7, rd, rd12);
        check("above_ctrl_rd7", rd, 32'h0);
        bus_read(CTRL, rd, rd12);
        check("above_ctrl_no_side_effect", rd, 32'h0);
        addr = 13'h0004; cs = 1'b0; #1;
        check("cs_low_read", dataOut, 32'h0);

        // Commit, swapOk five cycles later
        check("pre_commit_pending", {127'h0, pending}, 128'h0);
        bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
        check("pend_cyc0", {127'h0, pending}, 128'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pend_wait", {126'h0, swapDone, pending}, 128'h1);
        end
        swapOk = 1'b1;
        tick();
        swapOk = 1'b0;
        check("swap_coeff2", {112'h0, coeffs[2*16 +: 16]}, 128'h0123);
        check("swap_coeff3", {112'h0, coeffs[3*16 +: 16]}, 128'hFF3A);
        check("swap_coeffs_all", coeffs, 128'h0000_0000_0000_0000_FF3A_0123_1100_00DD);
        check("swap_pending_low", {127'h0, pending}, 128'h0);
        check("swapdone_high", {127'h0, swapDone}, 128'h1);
        tick();
        check("swapdone_low", {127'h0, swapDone}, 128'h0);
        bus_read(CTRL, rd, rd12);
        check("swapcnt_1", rd, 32'h0001_0000);

        // Writes while pending
        bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
        bus_write(0, 0, 32'h1111_2222, 4'b1111);
        bus_read(0, rd, rd12);
        check("wp_shadow_kept", rd, 32'h1100_00DD);
        bus_read(CTRL, rd, rd12);
        check("wp_wrerr_set", rd, 32'h0001_0300);
        bus_write(0, CTRL, 32'h0000_0200, 4'b0010);
        bus_read(CTRL, rd, rd12);
        check("wp_wrerr_clr", rd, 32'h0001_0100);

        // Coefficient write on the swap edge is discarded
        swapOk = 1'b1;
        bus_write(0, 1, 32'h5555_6666, 4'b1111);
        swapOk = 1'b0;
        check("swapedge_pending", {127'h0, pending}, 128'h0);
        check("swapedge_done", {127'h0, swapDone}, 128'h1);
        check("swapedge_coeffs", coeffs, 128'h0000_0000_0000_0000_FF3A_0123_1100_00DD);
        bus_read(1, rd, rd12);
        check("swapedge_w1_kept", rd, 32'hFF3A_0123);
        bus_read(CTRL, rd, rd12);
        check("swapedge_ctrl", rd, 32'h0002_0200);
        bus_write(0, CTRL, 32'h0000_0200, 4'b0010);
        bus_read(CTRL, rd, rd12);
        check("wrerr_clr2", rd, 32'h0002_0000);

        // banksel bit (present only with the build option)
        bus_write(0, CTRL, 32'h0000_0010, 4'b0001);
        bus_read(CTRL, rd, rd12);
        check("banksel_rb", rd, 32'h0002_0000 | BANKSEL_RB);
        bus_read(1, rd, rd12);
        check("banksel_w1", rd, 32'hFF3A_0123);

        // Narrow width CW = 12
        bus_write(1, 0, 32'h0000_0800, 4'b0011);
        bus_read(0, rd, rd12);
        check("cw12_sext", rd12, 32'h0000_F800);
        bus_write(1, 1, 32'h37FF_0000, 4'b1100);
        bus_read(1, rd, rd12);
        check("cw12_upper_ignored", rd12, 32'h07FF_0000);
        bus_write(1, CTRL, 32'h0000_0001, 4'b0001);
        swapOk = 1'b1;
        tick();
        swapOk = 1'b0;
        check("cw12_coeff0", {116'h0, coeffs12[11:0]}, 128'h800);
        check("cw12_coeff3", {116'h0, coeffs12[3*12 +: 12]}, 128'h7FF);
        check("cw12_dut_unaffected", {126'h0, swapDone, pending}, 128'h0);

        // Commit with simultaneous swapOk: no swap
        swapOk = 1'b1;
        bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
        swapOk = 1'b0;
        check("commit_swapok_pending", {127'h0, pending}, 128'h1);
        check("commit_swapok_nodone", {127'h0, swapDone}, 128'h0);
        bus_read(CTRL, rd, rd12);
        check("commit_swapok_cnt", rd, 32'h0002_0100);
        swapOk = 1'b1;
        tick();
        swapOk = 1'b0;
        check("later_swap_done", {127'h0, swapDone}, 128'h1);
        bus_read(CTRL, rd, rd12);
        check("later_swap_cnt", rd, 32'h0003_0000);

        // Commit on the swap edge re-arms; wrap swapCnt
        bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
        for (int i = 0; i < 252; i++) begin
            swapOk = 1'b1;
            bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
            swapOk = 1'b0;
            if (i == 0) begin
                check("rearm_pending", {127'h0, pending}, 128'h1);
                check("rearm_done", {127'h0, swapDone}, 128'h1);
            end
        end
        bus_read(CTRL, rd, rd12);
        check("cnt_255", rd, 32'h00FF_0100);
        swapOk = 1'b1;
        tick();
        swapOk = 1'b0;
        bus_read(CTRL, rd, rd12);
        check("cnt_wrap_0", rd, 32'h0000_0000);

        // Reset mid-PEND
        bus_write(0, CTRL, 32'h0000_0001, 4'b0001);
        check("midrst_pending_before", {127'h0, pending}, 128'h1);
        #2 nReset = 1'b0;
        #1;
        check("midrst_pending", {127'h0, pending}, 128'h0);
        check("midrst_coeffs", coeffs, 128'h0);
        @(negedge busClk);
        nReset = 1'b1;
        swapOk = 1'b1;
        tick();
        swapOk = 1'b0;
        tick();
        check("midrst_no_swap", {126'h0, swapDone, pending}, 128'h0);
        bus_read(CTRL, rd, rd12);
        check("midrst_ctrl", rd, 32'h0);
        bus_read(1, rd, rd12);
        check("midrst_shadow", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
